// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 data mux among eight requesters.
// Define ARB_BURST_EN to allow up to BURST_LEN transfers per grant.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req       : per-requester request, bit i = requester i
//   in_data   : packed lanes, lane i = in_data[i*DATA_W +: DATA_W]
//   out_ready : downstream accept
//   out_valid : out_data valid (req of the granted requester)
//   out_data  : selected lane, muxed by sel
//   sel       : registered mux select, index of granted requester
//   grant     : registered one-hot grant, zero when idle
//   busy      : high while a grant is held
module mux8_rr_arbiter #(
  parameter int DATA_W    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        sel,
  output logic [7:0]        grant,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state, state_n;
  logic [2:0]  sel_n;
  logic [2:0]  ptr, ptr_n;
  logic [7:0]  grant_n;
  logic [3:0]  pk_idle;
  logic [3:0]  pk_rot;
  logic [DATA_W-1:0] lane [8];

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_chk
    $error("BURST_LEN out of range");
  end

  // {found, index} of the first set bit of r, scanning upward
  // from start and wrapping mod 8.
  function automatic logic [3:0] pick(
    input logic [7:0] r,
    input logic [2:0] start
  );
    logic [2:0] idx;
    pick = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[i] = in_data[i*DATA_W +: DATA_W];
  end

  assign out_data  = lane[sel];
  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];

  // grant is one-hot on sel while busy, so masking by it
  // removes the current owner from the rotation search.
  assign pk_idle = pick(req, ptr);
  assign pk_rot  = pick(req & ~grant, sel + 3'd1);

`ifdef ARB_BURST_EN
  logic [4:0] cnt, cnt_n;
  logic [4:0] cnt_inc;

  assign cnt_inc = cnt + 5'd1;
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    grant_n = grant;
`ifdef ARB_BURST_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (pk_idle[3]) begin
          state_n = GRANT;
          sel_n   = pk_idle[2:0];
          grant_n = 8'd1 << pk_idle[2:0];
`ifdef ARB_BURST_EN
          cnt_n   = 5'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_n = IDLE;
          grant_n = 8'd0;
        end else if (out_ready) begin
`ifdef ARB_BURST_EN
          if (cnt_inc < 5'(BURST_LEN)) begin
            cnt_n = cnt_inc;
          end else begin
            ptr_n = sel + 3'd1;
            cnt_n = 5'd0;
            if (pk_rot[3]) begin
              sel_n   = pk_rot[2:0];
              grant_n = 8'd1 << pk_rot[2:0];
            end
          end
`else
          ptr_n = sel + 3'd1;
          if (pk_rot[3]) begin
            sel_n   = pk_rot[2:0];
            grant_n = 8'd1 << pk_rot[2:0];
          end else begin
            state_n = IDLE;
            grant_n = 8'd0;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      grant <= 8'd0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      grant <= grant_n;
    end
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge clk) begin
    if (rst) cnt <= 5'd0;
    else     cnt <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: vector table,
// directed corner sequences and a randomized reference model.
module tb_mux8_rr_arbiter;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [0:0] out_data;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.DATA_W(1), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .sel(sel), .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: current owner (-1 = none), priority
  // pointer, transfers under this grant, last select.
  int owner, mptr, mcnt, msel;

`ifdef ARB_BURST_EN
  localparam int LIMIT = BL;
  localparam bit BURST = 1'b1;
`else
  localparam int LIMIT = 1;
  localparam bit BURST = 1'b0;
`endif

  function automatic int first_from(input logic [7:0] r,
                                    input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] q,
                       input logic [7:0] d, input logic rd);
    @(negedge clk);
    rst = r; req = q; in_data = d; out_ready = rd;
    #1;
  endtask

  task automatic model_edge();
    int w;
    logic [7:0] m;
    @(posedge clk);
    if (rst) begin
      owner = -1; mptr = 0; mcnt = 0; msel = 0;
    end else if (owner < 0) begin
      w = first_from(req, mptr);
      if (w >= 0) begin owner = w; msel = w; mcnt = 0; end
    end else if (!req[owner]) begin
      owner = -1;
    end else if (out_ready) begin
      mcnt++;
      if (mcnt >= LIMIT) begin
        mptr = (owner + 1) % 8;
        m = req;
        m[owner] = 1'b0;
        w = first_from(m, mptr);
        mcnt = 0;
        if (w >= 0) begin owner = w; msel = w; end
        else if (!BURST) owner = -1;
      end
    end
  endtask

  task automatic mcheck();
    logic [7:0] eg;
    logic ev;
    eg = 8'd0;
    if (owner >= 0) eg[owner] = 1'b1;
    ev = (owner >= 0) && req[msel];
    chk("m_sel", 32'(sel), 32'(msel));
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_busy", 32'(busy), 32'(owner >= 0));
    chk("m_valid", 32'(out_valid), 32'(ev));
    chk("m_data", 32'(out_data), 32'(in_data[msel]));
  endtask

  task automatic step(input logic r, input logic [7:0] q,
                      input logic [7:0] d, input logic rd);
    apply(r, q, d, rd);
    mcheck();
    model_edge();
  endtask

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       rd;
    logic [2:0] esel;
    logic [7:0] egnt;
    logic       eval;
    logic       ebusy;
    logic       edata;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(logic r, logic [7:0] q, logic rd,
                              logic [2:0] s, logic [7:0] g,
                              logic v, logic b, logic dd);
    vec_t x;
    x.r = r; x.q = q; x.rd = rd; x.esel = s; x.egnt = g;
    x.eval = v; x.ebusy = b; x.edata = dd;
    return x;
  endfunction

  logic [7:0] rq;

  initial begin
    rst = 1'b1; req = 8'hFF; in_data = 8'hAA; out_ready = 1'b0;
    owner = -1; mptr = 0; mcnt = 0; msel = 0;
    model_edge();
    model_edge();

    // lane i carries i[0] (in_data = 8'hAA)
    vt.push_back(mk(1, 8'hFF, 0, 0, 8'h00, 0, 0, 0));
    vt.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g;
      g = 8'd1 << (i % 8);
      vt.push_back(mk(0, 8'hFF, 1, 3'(i % 8), g, 1, 1,
                      (i % 2) == 1));
    end
    vt.push_back(mk(0, 8'h00, 0, 1, 8'h02, 0, 1, 1));
    vt.push_back(mk(0, 8'h10, 0, 1, 8'h00, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 8'h10, 0, 4, 8'h10, 1, 1, 0));
    vt.push_back(mk(0, 8'h10, 1, 4, 8'h10, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 4, 8'h00, 0, 0, 0));

    foreach (vt[i]) begin
      apply(vt[i].r, vt[i].q, 8'hAA, vt[i].rd);
      chk($sformatf("t%0d_sel", i), 32'(sel), 32'(vt[i].esel));
      chk($sformatf("t%0d_grant", i), 32'(grant), 32'(vt[i].egnt));
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(vt[i].eval));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(vt[i].ebusy));
      chk($sformatf("t%0d_data", i), 32'(out_data), 32'(vt[i].edata));
      model_edge();
    end

    // pointer wrap: transfer from 6 leaves ptr=7
    step(0, 8'h40, 8'hAA, 1);
    step(0, 8'h40, 8'hAA, 1);
    step(0, 8'h81, 8'hAA, 1);
    apply(0, 8'h81, 8'hAA, 1);
    chk("wrap_sel7", 32'(sel), 32'd7);
    mcheck(); model_edge();
    apply(0, 8'h81, 8'hAA, 1);
    chk("wrap_grant0", 32'(grant), 32'h01);
    mcheck(); model_edge();

    // abort: requester 3 drops req before ready
    step(0, 8'h08, 8'hAA, 0);
    step(0, 8'h08, 8'hAA, 0);
    apply(0, 8'h08, 8'hAA, 0);
    chk("abort_grant3", 32'(grant), 32'h08);
    mcheck(); model_edge();
    apply(0, 8'h00, 8'hAA, 1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    mcheck(); model_edge();
    apply(0, 8'h00, 8'hAA, 0);
    chk("abort_idle", 32'(busy), 32'd0);
    mcheck(); model_edge();
    step(0, 8'h0A, 8'hAA, 0);
    apply(0, 8'h0A, 8'hAA, 0);
    chk("abort_ptr", 32'(sel), 32'd1);
    mcheck(); model_edge();

    // reset while granted
    apply(1, 8'h0A, 8'hAA, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    model_edge();
    apply(0, 8'h0A, 8'hAA, 0);
    chk("mid_grant", 32'(grant), 32'h00);
    chk("mid_sel", 32'(sel), 32'd0);
    mcheck(); model_edge();

    // two requesters, continuous ready
    for (int i = 0; i < 8; i++) begin
      int es;
      if (BURST) es = (i < BL) ? 1 : 2;
      else       es = (i % 2 == 0) ? 1 : 2;
      apply(0, 8'h06, 8'hAA, 1);
      chk($sformatf("pair%0d_sel", i), 32'(sel), 32'(es));
      mcheck(); model_edge();
    end

    // randomized traffic with occasional reset
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      step($urandom_range(0, 99) == 0, rq, 8'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
